// File: rtl/branch_predict_control.sv
// ============================================================================
// branch_predict_control
//
// Branch direction predictor and resolver for the 2-byte-instruction pipeline.
// A direct-mapped table of 2-bit saturating counters, indexed by PC, supplies
// a taken/not-taken prediction to IF. The same block resolves the actual
// direction of BLT/BGT/BE/JMP in EX from the comparator result, flags a
// misprediction for the PC mux, and raises a registered one-cycle flush pulse
// that squashes the wrong-path instruction sitting in ID.
//
// Optional feature macro: BRANCH_STATS_EN
//   defined   -> 16-bit saturating branch/mispredict statistics counters
//   undefined -> branch_count and mispredict_count are tied to 16'h0000
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   stall             pipeline stall; blocks every state update
//   if_pc             PC of the instruction in IF
//   if_opcode         opcode of the instruction in IF
//   if_pred_taken     combinational prediction for the IF instruction
//   ex_valid          EX holds a real instruction
//   ex_pc             PC of the instruction in EX
//   ex_opcode         opcode of the instruction in EX
//   ex_cmp_result     GREATER=00, LESS=01, EQUAL=10, UNKNOWN=11
//   ex_pred_taken     prediction made for the EX instruction back in IF
//   ex_taken          resolved direction (combinational)
//   mispredict        redirect the PC this cycle (combinational)
//   redirect_fallthru when mispredict: 1 = ex_pc+2, 0 = branch target
//   flush_q           registered pulse one cycle after an accepted mispredict
//   branch_count      accepted conditional branches (feature-gated)
//   mispredict_count  accepted mispredictions (feature-gated)
// ============================================================================
module branch_predict_control #(
    parameter int         PC_W      = 16,
    parameter int         BHT_DEPTH = 16,
    parameter int         IDX_LSB   = 1,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [PC_W-1:0] if_pc,
    input  logic [3:0]      if_opcode,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [3:0]      ex_opcode,
    input  logic [1:0]      ex_cmp_result,
    input  logic            ex_pred_taken,
    output logic            ex_taken,
    output logic            mispredict,
    output logic            redirect_fallthru,
    output logic            flush_q,
    output logic [15:0]     branch_count,
    output logic [15:0]     mispredict_count
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    typedef enum logic [3:0] {
        OP_BLT = 4'b0100,
        OP_BGT = 4'b0101,
        OP_BE  = 4'b0110,
        OP_JMP = 4'b1100
    } opcode_e;

    typedef enum logic [1:0] {
        CMP_GREATER = 2'b00,
        CMP_LESS    = 2'b01,
        CMP_EQUAL   = 2'b10,
        CMP_UNKNOWN = 2'b11
    } cmp_e;

    // Parameter sanity: the table must be a power of two with at least two
    // entries, and the index field must fit inside the PC.
    if (BHT_DEPTH < 2 || (BHT_DEPTH & (BHT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("branch_predict_control: BHT_DEPTH must be a power of two >= 2");
    end
    if (IDX_LSB + IDX_W > PC_W) begin : g_bad_index
        $error("branch_predict_control: index field exceeds PC width");
    end

    logic [1:0]       bht [BHT_DEPTH];
    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             ex_is_cond;
    logic             accept;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_next;

    // Only the index slice of each PC matters here; the remaining bits are
    // folded into a sink so the unused-bit intent is explicit.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc, ex_pc};

    assign if_idx = if_pc[IDX_LSB +: IDX_W];
    assign ex_idx = ex_pc[IDX_LSB +: IDX_W];

    // IF prediction. The table is read combinationally from the registered
    // array, so a same-cycle update from EX is never visible here until the
    // following cycle (read-old behaviour).
    always_comb begin
        if_pred_taken = 1'b0;
        case (if_opcode)
            OP_JMP:               if_pred_taken = 1'b1;
            OP_BLT, OP_BGT, OP_BE: if_pred_taken = bht[if_idx][1];
            default:              if_pred_taken = 1'b0;
        endcase
    end

    // EX resolution from the comparator. UNKNOWN never satisfies a
    // conditional branch, and a bubble in EX always resolves not-taken.
    always_comb begin
        ex_taken = 1'b0;
        if (ex_valid) begin
            case (ex_opcode)
                OP_BLT:  ex_taken = (ex_cmp_result == CMP_LESS);
                OP_BGT:  ex_taken = (ex_cmp_result == CMP_GREATER);
                OP_BE:   ex_taken = (ex_cmp_result == CMP_EQUAL);
                OP_JMP:  ex_taken = 1'b1;
                default: ex_taken = 1'b0;
            endcase
        end
    end

    always_comb begin
        ex_is_cond = 1'b0;
        case (ex_opcode)
            OP_BLT, OP_BGT, OP_BE: ex_is_cond = 1'b1;
            default:               ex_is_cond = 1'b0;
        endcase
    end

    // Mispredict is reported even while stalled so the PC mux sees it early;
    // it only takes effect on state once the stall drops.
    assign mispredict        = ex_valid & (ex_taken ^ ex_pred_taken);
    assign redirect_fallthru = mispredict & ~ex_taken;
    assign accept            = ex_valid & ~stall;

    // Saturating step of the addressed counter toward the resolved outcome.
    always_comb begin
        cnt_cur  = bht[ex_idx];
        cnt_next = cnt_cur;
        if (ex_taken) begin
            if (cnt_cur != 2'b11) begin
                cnt_next = cnt_cur + 2'b01;
            end
        end else begin
            if (cnt_cur != 2'b00) begin
                cnt_next = cnt_cur - 2'b01;
            end
        end
    end

    // Counter table. Reset wins over stall and over any concurrent update, so
    // a branch that sits in EX during reset is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (accept && ex_is_cond) begin
            bht[ex_idx] <= cnt_next;
        end
    end

    // Flush pulse: follows each accepted edge, and freezes during a stall so
    // a pending squash is not lost while ID is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_q <= 1'b0;
        end else if (!stall) begin
            flush_q <= accept & mispredict;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] mispredict_cnt_q;

    // Statistics: both counters stick at all-ones rather than wrapping so a
    // long run never reports a misleadingly small figure.
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= 16'h0000;
            mispredict_cnt_q <= 16'h0000;
        end else if (accept) begin
            if (ex_is_cond && branch_cnt_q != 16'hFFFF) begin
                branch_cnt_q <= branch_cnt_q + 16'h0001;
            end
            if (mispredict && mispredict_cnt_q != 16'hFFFF) begin
                mispredict_cnt_q <= mispredict_cnt_q + 16'h0001;
            end
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispredict_cnt_q;
`else
    assign branch_count     = 16'h0000;
    assign mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predict_control.sv
// ============================================================================
// tb_branch_predict_control
//
// Self-checking bench for branch_predict_control (default parameters). A
// behavioural model keeps each counter as an integer 0..3 and derives the
// prediction, resolution and flush from the branch rules directly. Scenario
// tasks drive directed cases, then a randomized run compares every cycle.
// ============================================================================
module tb_branch_predict_control;

    localparam logic [3:0] BLT = 4'b0100;
    localparam logic [3:0] BGT = 4'b0101;
    localparam logic [3:0] BE  = 4'b0110;
    localparam logic [3:0] JMP = 4'b1100;
    localparam logic [3:0] NOP = 4'b0000;

    localparam logic [1:0] GREATER = 2'b00;
    localparam logic [1:0] LESS    = 2'b01;
    localparam logic [1:0] EQUAL   = 2'b10;
    localparam logic [1:0] UNKNOWN = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [15:0] if_pc;
    logic [3:0]  if_opcode;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic [3:0]  ex_opcode;
    logic [1:0]  ex_cmp_result;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic        mispredict;
    logic        redirect_fallthru;
    logic        flush_q;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt [16];
    bit m_flush;
    int m_bc;
    int m_mc;

    branch_predict_control dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .if_pc             (if_pc),
        .if_opcode         (if_opcode),
        .if_pred_taken     (if_pred_taken),
        .ex_valid          (ex_valid),
        .ex_pc             (ex_pc),
        .ex_opcode         (ex_opcode),
        .ex_cmp_result     (ex_cmp_result),
        .ex_pred_taken     (ex_pred_taken),
        .ex_taken          (ex_taken),
        .mispredict        (mispredict),
        .redirect_fallthru (redirect_fallthru),
        .flush_q           (flush_q),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int m_idx(input logic [15:0] pc);
        return (int'(pc) / 2) % 16;
    endfunction

    function automatic bit m_is_cond(input logic [3:0] op);
        return (op == BLT) || (op == BGT) || (op == BE);
    endfunction

    function automatic bit m_pred(input logic [15:0] pc, input logic [3:0] op);
        if (op == JMP) return 1'b1;
        if (m_is_cond(op)) return (m_cnt[m_idx(pc)] >= 2);
        return 1'b0;
    endfunction

    function automatic bit m_taken();
        if (!ex_valid) return 1'b0;
        if (ex_opcode == JMP) return 1'b1;
        if (ex_opcode == BLT) return ex_cmp_result == LESS;
        if (ex_opcode == BGT) return ex_cmp_result == GREATER;
        if (ex_opcode == BE)  return ex_cmp_result == EQUAL;
        return 1'b0;
    endfunction

    function automatic bit m_mispredict();
        return ex_valid && (m_taken() != ex_pred_taken);
    endfunction

    function automatic int exp_bc();
`ifdef BRANCH_STATS_EN
        return m_bc;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_mc();
`ifdef BRANCH_STATS_EN
        return m_mc;
`else
        return 0;
`endif
    endfunction

    // Advance the model with the inputs present at the coming edge, then
    // let the edge happen and settle just past it.
    task automatic tick();
        bit t;
        bit mp;
        int k;
        t  = m_taken();
        mp = m_mispredict();
        k  = m_idx(ex_pc);
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 1;
            m_flush = 0;
            m_bc    = 0;
            m_mc    = 0;
        end else if (!stall) begin
            m_flush = ex_valid && mp;
            if (ex_valid && m_is_cond(ex_opcode)) begin
                if (t) m_cnt[k] = (m_cnt[k] == 3) ? 3 : m_cnt[k] + 1;
                else   m_cnt[k] = (m_cnt[k] == 0) ? 0 : m_cnt[k] - 1;
                if (m_bc < 65535) m_bc++;
            end
            if (ex_valid && mp && m_mc < 65535) m_mc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input bit v, input logic [15:0] pc, input logic [3:0] op,
                          input logic [1:0] cmp, input bit pred);
        ex_valid      = v;
        ex_pc         = pc;
        ex_opcode     = op;
        ex_cmp_result = cmp;
        ex_pred_taken = pred;
    endtask

    task automatic set_if(input logic [15:0] pc, input logic [3:0] op);
        if_pc     = pc;
        if_opcode = op;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        set_ex(1'b1, 16'h0004, BLT, LESS, 1'b0);
        stall = 1'b1;
        rst   = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        set_if(16'h0004, BLT);
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_pred got %0b exp 0", if_pred_taken); end
        checks++; if (flush_q !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush got %0b exp 0", flush_q); end
        checks++; if (branch_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_bcount got %0d exp 0", branch_count); end
        checks++; if (mispredict_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_mcount got %0d exp 0", mispredict_count); end
        for (int i = 0; i < 16; i++) begin
            set_if(16'(i * 2), BE);
            #1;
            checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_entry%0d got %0b exp 0", i, if_pred_taken); end
        end
    endtask

    task automatic test_be_taken();
        set_if(16'h0004, BE);
        for (int n = 0; n < 2; n++) begin
            set_ex(1'b1, 16'h0004, BE, EQUAL, 1'b0);
            #1;
            checks++; if (mispredict !== 1'b1) begin errors++; $display("[TB] FAIL be_mispredict got %0b exp 1", mispredict); end
            checks++; if (redirect_fallthru !== 1'b0) begin errors++; $display("[TB] FAIL be_redirect got %0b exp 0", redirect_fallthru); end
            checks++; if (ex_taken !== 1'b1) begin errors++; $display("[TB] FAIL be_taken got %0b exp 1", ex_taken); end
            tick();
            checks++; if (flush_q !== 1'b1) begin errors++; $display("[TB] FAIL be_flush got %0b exp 1", flush_q); end
        end
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        #1;
        checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL be_pred_after got %0b exp 1", if_pred_taken); end
        checks++; if (m_cnt[2] != 3) begin errors++; $display("[TB] FAIL be_model_entry got %0d exp 3", m_cnt[2]); end
        tick();
        checks++; if (flush_q !== 1'b0) begin errors++; $display("[TB] FAIL be_flush_clear got %0b exp 0", flush_q); end
        // One not-taken outcome from strong-taken must still predict taken.
        set_ex(1'b1, 16'h0004, BE, GREATER, 1'b1);
        tick();
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        #1;
        checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL be_strong_hold got %0b exp 1", if_pred_taken); end
    endtask

    task automatic test_unknown();
        set_ex(1'b1, 16'h0008, BGT, UNKNOWN, 1'b1);
        set_if(16'h0008, BGT);
        #1;
        checks++; if (ex_taken !== 1'b0) begin errors++; $display("[TB] FAIL unk_taken got %0b exp 0", ex_taken); end
        checks++; if (mispredict !== 1'b1) begin errors++; $display("[TB] FAIL unk_mispredict got %0b exp 1", mispredict); end
        checks++; if (redirect_fallthru !== 1'b1) begin errors++; $display("[TB] FAIL unk_redirect got %0b exp 1", redirect_fallthru); end
        tick();
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        set_ex(1'b1, 16'h0008, BGT, GREATER, 1'b0);
        tick();
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        #1;
        // 01 -> 00 -> 01: a single taken step must not reach the taken half.
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL unk_decrement got %0b exp 0", if_pred_taken); end
    endtask

    task automatic test_jmp();
        int bc_before;
        bc_before = exp_bc();
        set_ex(1'b1, 16'h0010, JMP, UNKNOWN, 1'b1);
        set_if(16'h0010, JMP);
        #1;
        checks++; if (ex_taken !== 1'b1) begin errors++; $display("[TB] FAIL jmp_taken got %0b exp 1", ex_taken); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("[TB] FAIL jmp_mispredict got %0b exp 0", mispredict); end
        checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL jmp_pred got %0b exp 1", if_pred_taken); end
        tick();
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        set_if(16'h0010, BLT);
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL jmp_no_update got %0b exp 0", if_pred_taken); end
        checks++; if (int'(branch_count) != bc_before) begin errors++; $display("[TB] FAIL jmp_bcount got %0d exp %0d", branch_count, bc_before); end
    endtask

    task automatic test_collision();
        do_reset();
        set_if(16'h0024, BLT);
        set_ex(1'b1, 16'h0004, BLT, LESS, 1'b0);
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL coll_old got %0b exp 0", if_pred_taken); end
        tick();
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        #1;
        checks++; if (if_pred_taken !== 1'b1) begin errors++; $display("[TB] FAIL coll_new got %0b exp 1", if_pred_taken); end
    endtask

    task automatic test_stall();
        do_reset();
        set_if(16'h000C, BLT);
        set_ex(1'b1, 16'h000C, BLT, LESS, 1'b0);
        stall = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            checks++; if (mispredict !== 1'b1) begin errors++; $display("[TB] FAIL stall_mp%0d got %0b exp 1", n, mispredict); end
            tick();
            checks++; if (flush_q !== 1'b0) begin errors++; $display("[TB] FAIL stall_flush%0d got %0b exp 0", n, flush_q); end
        end
        stall = 1'b0;
        #1;
        checks++; if (mispredict !== 1'b1) begin errors++; $display("[TB] FAIL stall_mp_release got %0b exp 1", mispredict); end
        tick();
        checks++; if (flush_q !== 1'b1) begin errors++; $display("[TB] FAIL stall_flush_pulse got %0b exp 1", flush_q); end
        checks++; if (int'(branch_count) != exp_bc()) begin errors++; $display("[TB] FAIL stall_bcount got %0d exp %0d", branch_count, exp_bc()); end
        checks++; if (int'(mispredict_count) != exp_mc()) begin errors++; $display("[TB] FAIL stall_mcount got %0d exp %0d", mispredict_count, exp_mc()); end
`ifdef BRANCH_STATS_EN
        checks++; if (branch_count !== 16'd1 || mispredict_count !== 16'd1) begin errors++; $display("[TB] FAIL stall_counts got %0d/%0d exp 1/1", branch_count, mispredict_count); end
`endif
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        tick();
        checks++; if (flush_q !== 1'b0) begin errors++; $display("[TB] FAIL stall_flush_end got %0b exp 0", flush_q); end
        // Exactly one step (01->10): a single not-taken must drop to not-taken.
        set_ex(1'b1, 16'h000C, BLT, GREATER, 1'b1);
        tick();
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        #1;
        checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL stall_single_update got %0b exp 0", if_pred_taken); end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 24; n++) begin
            set_ex(1'b1, 16'(n * 2), BE, EQUAL, 1'b0);
            tick();
        end
        rst = 1'b1;
        set_ex(1'b1, 16'h0002, BLT, LESS, 1'b0);
        tick();
        rst = 1'b0;
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        #1;
        checks++; if (flush_q !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flush got %0b exp 0", flush_q); end
        checks++; if (branch_count !== 16'd0) begin errors++; $display("[TB] FAIL rmid_bcount got %0d exp 0", branch_count); end
        for (int i = 0; i < 16; i++) begin
            set_if(16'(i * 2), BGT);
            #1;
            checks++; if (if_pred_taken !== 1'b0) begin errors++; $display("[TB] FAIL rmid_entry%0d got %0b exp 0", i, if_pred_taken); end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        bit         e_pred;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0:       op = BLT;
                1:       op = BGT;
                2:       op = BE;
                3:       op = JMP;
                default: op = 4'($urandom_range(0, 15));
            endcase
            set_ex(1'($urandom_range(0, 3) != 0), 16'($urandom), op,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            case ($urandom_range(0, 3))
                0:       set_if(16'($urandom), BLT);
                1:       set_if(16'($urandom), BE);
                2:       set_if(16'($urandom), JMP);
                default: set_if(16'($urandom), 4'($urandom_range(0, 15)));
            endcase
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            #1;
            e_pred = m_pred(if_pc, if_opcode);
            checks++; if (if_pred_taken !== e_pred) begin errors++; $display("[TB] FAIL rnd_pred c%0d got %0b exp %0b", n, if_pred_taken, e_pred); end
            checks++; if (ex_taken !== m_taken()) begin errors++; $display("[TB] FAIL rnd_taken c%0d got %0b exp %0b", n, ex_taken, m_taken()); end
            checks++; if (mispredict !== m_mispredict()) begin errors++; $display("[TB] FAIL rnd_mp c%0d got %0b exp %0b", n, mispredict, m_mispredict()); end
            checks++; if (redirect_fallthru !== (m_mispredict() && !m_taken())) begin errors++; $display("[TB] FAIL rnd_redirect c%0d got %0b exp %0b", n, redirect_fallthru, m_mispredict() && !m_taken()); end
            tick();
            checks++; if (flush_q !== m_flush) begin errors++; $display("[TB] FAIL rnd_flush c%0d got %0b exp %0b", n, flush_q, m_flush); end
            checks++; if (int'(branch_count) != exp_bc()) begin errors++; $display("[TB] FAIL rnd_bcount c%0d got %0d exp %0d", n, branch_count, exp_bc()); end
            checks++; if (int'(mispredict_count) != exp_mc()) begin errors++; $display("[TB] FAIL rnd_mcount c%0d got %0d exp %0d", n, mispredict_count, exp_mc()); end
        end
        rst   = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        set_if(16'h0000, NOP);
        set_ex(1'b0, 16'h0000, NOP, UNKNOWN, 1'b0);
        foreach (m_cnt[i]) m_cnt[i] = 1;
        m_flush = 0;
        m_bc    = 0;
        m_mc    = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_be_taken();
        test_unknown();
        test_jmp();
        test_collision();
        test_stall();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_control.md
Name: branch_predict_control

Overview:
- Parametrised successor to the combinational jump decision logic.
- Resolves BLT/BGT/BE/JMP in EX from the comparator result.
- Keeps a direct-mapped table of 2-bit saturating counters, indexed by PC, and gives IF a taken/not-taken prediction.
- Flags mispredictions and redirect source for the PC mux; emits a registered one-cycle flush pulse to squash the wrong-path instruction in ID.

Parameters:
- PC_W, 16, PC width in bits.
- BHT_DEPTH, 16, number of counter entries; power of two, minimum 2.
- IDX_LSB, 1, lowest PC bit used for the index (instructions are 2 bytes).
- CNT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- stall  in  1  pipeline stall; blocks all state updates
- if_pc  in  PC_W  PC of instruction in IF
- if_opcode  in  4  opcode of instruction in IF
- if_pred_taken  out  1  prediction for IF instruction (combinational)
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  PC_W  PC of EX instruction
- ex_opcode  in  4  opcode of EX instruction
- ex_cmp_result  in  2  comparator result: GREATER=00, LESS=01, EQUAL=10, UNKNOWN=11
- ex_pred_taken  in  1  prediction made for this instruction in IF, piped down
- ex_taken  out  1  resolved direction (combinational)
- mispredict  out  1  redirect PC this cycle (combinational)
- redirect_fallthru  out  1  when mispredict: 1 = ex_pc+2, 0 = branch target
- flush_q  out  1  registered, one cycle after an accepted mispredict
- branch_count  out  16  resolved conditional branches (feature-gated)
- mispredict_count  out  16  mispredictions (feature-gated)

Behaviour:
- Opcodes: BLT=0100, BGT=0101, BE=0110, JMP=1100; all others are non-branch.
- Index: idx = pc[IDX_LSB +: log2(BHT_DEPTH)].
- if_pred_taken:
  - JMP: 1.
  - BLT/BGT/BE: bht[idx(if_pc)][1].
  - Otherwise: 0.
- ex_taken (0 when ex_valid=0):
  - BLT: 1 if LESS.
  - BGT: 1 if GREATER.
  - BE: 1 if EQUAL.
  - JMP: 1 always.
  - UNKNOWN or non-branch: 0.
- mispredict = ex_valid & (ex_taken != ex_pred_taken). Asserts even when stall=1, but nothing is accepted while stalled.
- redirect_fallthru = mispredict & ~ex_taken.
- Accepted event = ex_valid & ~stall on a rising clk.
- Counter update on an accepted BLT/BGT/BE:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
  - JMP and non-branches never update.
- flush_q <= accepted & mispredict; cleared the next cycle unless re-triggered. Holds its value while stall=1.
- Same-index read/write in one cycle: IF sees the pre-update (old) value. Write-first is prohibited.
- Reset (rst=1 at clk edge): all counters = CNT_INIT, flush_q = 0, both counts = 0. Overrides stall and any concurrent update. A branch in EX during reset is dropped; no update.
- Latency:
  - Prediction and resolution are 0 cycles.
  - Table update is visible to IF from the cycle after the edge.
  - flush_q is 1 cycle after the mispredict.
- Counter state sequence per entry: 00 (strong NT) <-> 01 (weak NT) <-> 10 (weak T) <-> 11 (strong T), moving one step per accepted outcome.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined:
  - branch_count increments on every accepted BLT/BGT/BE.
  - mispredict_count increments on every accepted mispredict, JMP included.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: counters are not built; both ports are tied to 16'h0000.

Test Plan:
- Reset, then IF BLT at pc=0x0004 -> if_pred_taken=0 (CNT_INIT=01); all counts 0, flush_q=0.
- EX BE at pc=0x0004, cmp=EQUAL, pred=0, twice -> cycle 1: mispredict=1, redirect_fallthru=0; flush_q=1 next cycle; entry 2 goes 01->10->11; IF BE at 0x0004 now predicts 1.
- EX BGT at pc=0x0008, cmp=UNKNOWN, pred=1 -> ex_taken=0, mispredict=1, redirect_fallthru=1; entry 4 decrements.
- EX JMP, pred=1 -> ex_taken=1, mispredict=0, no table change, branch_count unchanged.
- Same-index collision: IF pc=0x0024 and EX pc=0x0004 (BHT_DEPTH=16, both idx 2), counter 01, EX taken -> IF sees 0 this cycle and 1 the next.
- EX BLT LESS with pred=0 and stall=1 for 3 cycles, then stall=0 -> mispredict=1 throughout; exactly one counter update; one flush_q pulse; with BRANCH_STATS_EN, counts = 1/1. Asserting rst mid-stream restores every entry to 01.
